pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage RV64I pipeline. It watches the instruction in decode, the destination/load status of the EX and MEM stages, the resolved branch/jump redirect from EX and the data-memory handshake. From these it drives the stall, bubble and flush enables and the PC source select for fetch, decode, EX and MEM. It replaces the ad-hoc stall logic inside decode with one FSM and keeps saturating hazard statistics counters.

## Interface
Parameters:
- FLUSH_CYCLES, 1: extra cycles IF/ID stays flushed after a redirect (fetch latency), range 1..7
- CNT_W, 32: width of statistics counters

Ports:
- CLK  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- id_inst  in  32  instruction currently in decode (NOP 32'h00000013 when empty)
- ex_rd  in  5  destination register of instruction in EX
- ex_wb  in  1  EX instruction writes back
- ex_load  in  1  EX instruction is a load
- mem_rd  in  5  destination register of instruction in MEM
- mem_load  in  1  MEM instruction is a load
- redirect  in  1  EX resolved taken branch or JAL/JALR redirect this cycle
- mem_req  in  1  MEM stage has an outstanding data access
- mem_ready  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_stall  out  1  hold EX/MEM and ID/EX registers
- pc_sel  out  2  0 = PC+4, 1 = redirect target, 2/3 reserved (never driven)
- stall_cnt  out  CNT_W  cycles with pc_stall asserted, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

## Operation
- Operand usage decoded from id_inst[6:0]: R, R-64, BRANCH, STORE use rs1 and rs2; I-arith, I-arith-64, LOAD, JALR use rs1 only; JAL, LUI, AUIPC and unknown opcodes use none. Register x0 never causes a hazard.
- Load-use hazard: ex_load and ex_rd matches a used source. Assert pc_stall, if_id_stall and id_ex_bubble.
- JALR hazard, because the target is computed in decode: id opcode JALR and either (ex_wb and ex_rd==rs1) or (mem_load and mem_rd==rs1). Same outputs as load-use.
- FSM states:
  - RUN: hazard outputs computed combinationally as above.
  - redirect -> pc_sel=1, if_id_flush=1, id_ex_bubble=1, flush_cnt+1, go FLUSH with counter=FLUSH_CYCLES-1. If that is 0, stay RUN.
  - mem_req and not mem_ready -> go MEM_WAIT.
  - FLUSH: if_id_flush=1, pc_sel=0, no stalls. The counter decrements and the FSM returns to RUN when it reaches 0. A new redirect restarts the flush; hazards are ignored while flushing.
  - MEM_WAIT: pc_stall, if_id_stall, ex_mem_stall=1, all else 0. A redirect seen here sets pending_redirect. On mem_ready, outputs are as for RUN that cycle. If pending_redirect or redirect, the redirect action is applied and pending is cleared.
- Priority in RUN: mem wait > redirect > JALR/load-use hazard.

## Timing
- All control outputs are Mealy, valid in the same cycle as their causing inputs. State and counters update on the rising edge of CLK.
- Hazard stall lasts exactly as long as the condition holds. Load-use stalls 1 cycle. JALR after a load stalls 2 cycles. JALR after an ALU op stalls 1 cycle.
- Redirect penalty: 1 + (FLUSH_CYCLES-1) flushed fetch slots.
- Reset (asserted at any time, including mid-FLUSH or mid-MEM_WAIT) takes effect immediately:
  - state RUN, pending cleared, counters 0;
  - all control outputs 0 and pc_sel 0 while reset is high.
- Counters saturate at all-ones; no wrap.

## Structure
- Shared package holds:
  - opcode constants (ARITHMETIC, ARITHMETIC_64, ARITHMETIC_IMM, ARITHMETIC_IMM_64, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - the NOP encoding;
  - pc_sel codes;
  - the FSM state encoding.
- One sub-module, operand_usage_decode: combinational, id_inst -> uses_rs1, uses_rs2, is_jalr. It is shared later with decode.

## Test plan
- ex_load=1, ex_rd=5, id_inst=add x1,x5,x6 -> pc_stall/if_id_stall/id_ex_bubble=1 one cycle; stall_cnt=1.
- id_inst=jalr x0,0(x7), ex_load=1 ex_rd=7, then next cycle mem_load=1 mem_rd=7 -> stall 2 consecutive cycles, then release.
- FLUSH_CYCLES=3, redirect pulse -> pc_sel=1 cycle 0; if_id_flush high cycles 0..2; flush_cnt=1.
- mem_req=1, mem_ready low 4 cycles with redirect=1 held -> freeze 4 cycles, then the redirect is applied on the mem_ready cycle, once only.
- id_inst=lui x5 with ex_load ex_rd=5, and add x0 source case -> no stall.
- Reset asserted mid-FLUSH -> outputs 0 immediately, RUN after release; preload counters to all-ones -> no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller and the
// decode stage: RV64I major opcodes, the canonical NOP, PC source select
// codes and the controller FSM state encoding.
// No ports (package).

package pipeline_hazard_ctrl_pkg;

  // RV64I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_ARITHMETIC        = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_64     = 7'b0111011;
  localparam logic [6:0] OP_ARITHMETIC_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ARITHMETIC_IMM_64 = 7'b0011011;
  localparam logic [6:0] OP_LOAD              = 7'b0000011;
  localparam logic [6:0] OP_STORE             = 7'b0100011;
  localparam logic [6:0] OP_BRANCH            = 7'b1100011;
  localparam logic [6:0] OP_JAL               = 7'b1101111;
  localparam logic [6:0] OP_JALR              = 7'b1100111;
  localparam logic [6:0] OP_LUI               = 7'b0110111;
  localparam logic [6:0] OP_AUIPC             = 7'b0010111;

  // addi x0, x0, 0 -- what an empty pipeline slot holds
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // PC source select; codes 2 and 3 are reserved and never driven
  localparam logic [1:0] PC_SEL_PLUS4    = 2'd0;
  localparam logic [1:0] PC_SEL_REDIRECT = 2'd1;

  // Controller FSM states
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_operand_usage_decode.sv
// operand_usage_decode
// Combinational decode of which source registers an instruction reads.
// Shared between the hazard controller and the decode stage.
// Ports:
//   id_inst   in  32  instruction in decode
//   uses_rs1  out 1   instruction reads rs1 (bits [19:15])
//   uses_rs2  out 1   instruction reads rs2 (bits [24:20])
//   is_jalr   out 1   instruction is JALR (target computed in decode)

module operand_usage_decode
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_jalr
);

  logic [6:0] opcode;
  logic       is_nop;

  assign opcode = id_inst[6:0];
  // The canonical bubble is flagged explicitly so an empty slot never looks
  // like a register reader, even if the x0 rule were ever relaxed.
  assign is_nop = (id_inst == NOP_INST);

  // Opcode class -> operand usage. JAL/LUI/AUIPC and unknown opcodes read no
  // registers, so fields that merely alias rs1/rs2 bit positions are ignored.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_jalr  = 1'b0;
    case (opcode)
      OP_ARITHMETIC, OP_ARITHMETIC_64, OP_BRANCH, OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_ARITHMETIC_IMM, OP_ARITHMETIC_IMM_64, OP_LOAD: begin
        uses_rs1 = ~is_nop;
      end
      OP_JALR: begin
        uses_rs1 = 1'b1;
        is_jalr  = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush/redirect controller for the five-stage RV64I pipeline,
// with saturating hazard statistics.
// Parameters:
//   FLUSH_CYCLES  extra cycles IF/ID stays flushed after a redirect (1..7)
//   CNT_W         statistics counter width
// Ports:
//   CLK, reset            clock (rising edge), async active-high reset
//   id_inst               instruction in decode
//   ex_rd/ex_wb/ex_load   EX destination, writeback and load flags
//   mem_rd/mem_load       MEM destination and load flag
//   redirect              EX resolved a taken branch / jump this cycle
//   mem_req/mem_ready     data memory handshake
//   pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, pc_sel
//                         Mealy pipeline controls, valid same cycle
//   stall_cnt, flush_cnt  saturating counts of stall cycles / redirects

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wb,
  input  logic             ex_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_load,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic       uses_rs1, uses_rs2, is_jalr;
  logic [4:0] rs1, rs2;
  logic       load_use, jalr_dep, hazard;

  logic [1:0] state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       pending_q, pending_d;

  logic       freeze, hazard_stall, flushing, take_redirect;

  operand_usage_decode u_usage (
    .id_inst  (id_inst),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_jalr  (is_jalr)
  );

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  // Load-use: the loaded value is not forwardable until MEM completes.
  // JALR reads rs1 in decode, so it must also wait on an ALU result still in
  // EX and on a load still in MEM. x0 is hard-wired and never a dependency.
  assign load_use = ex_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
  assign jalr_dep = is_jalr && (rs1 != 5'd0) &&
                    ((ex_wb && (ex_rd == rs1)) || (mem_load && (mem_rd == rs1)));
  assign hazard   = load_use || jalr_dep;

  // Next-state and action decode. A memory wait outranks everything in RUN;
  // a redirect that arrives while frozen is remembered and applied on the
  // cycle memory completes. All redirect side effects are gathered at the end
  // so RUN, FLUSH (restart) and MEM_WAIT release share one path.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pending_d     = pending_q;
    freeze        = 1'b0;
    hazard_stall  = 1'b0;
    flushing      = 1'b0;
    take_redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze    = 1'b1;
          pending_d = redirect;
          state_d   = ST_MEM_WAIT;
        end else if (redirect) begin
          take_redirect = 1'b1;
        end else begin
          hazard_stall = hazard;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          take_redirect = 1'b1;
        end else begin
          flushing = 1'b1;
          fcnt_d   = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          freeze    = 1'b1;
          pending_d = pending_q | redirect;
        end else begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
          if (pending_q || redirect) begin
            take_redirect = 1'b1;
          end else begin
            hazard_stall = hazard;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (take_redirect) begin
      pending_d = 1'b0;
      fcnt_d    = FLUSH_RELOAD;
      state_d   = (FLUSH_RELOAD == 3'd0) ? ST_RUN : ST_FLUSH;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the
  // registered state that is being cleared.
  assign pc_stall     = ~reset & (freeze | hazard_stall);
  assign if_id_stall  = ~reset & (freeze | hazard_stall);
  assign ex_mem_stall = ~reset & freeze;
  assign if_id_flush  = ~reset & (take_redirect | flushing);
  assign id_ex_bubble = ~reset & (take_redirect | hazard_stall);
  assign pc_sel       = (!reset && take_redirect) ? PC_SEL_REDIRECT : PC_SEL_PLUS4;

  // State, flush counter, pending redirect and saturating statistics.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      fcnt_q    <= 3'd0;
      pending_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
      if ((freeze || hazard_stall) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (take_redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4) with a
// rule-level reference model checked every cycle and literal spot checks.

module tb_pipeline_hazard_ctrl;

  localparam int FC  = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          CLK;
  logic          reset;
  logic [31:0]   id_inst;
  logic [4:0]    ex_rd, mem_rd;
  logic          ex_wb, ex_load, mem_load, redirect, mem_req, mem_ready;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: flush slots still owed, frozen-on-memory flag,
  // remembered redirect and plain integer counters.
  int m_left = 0, m_stall = 0, m_flush = 0;
  bit m_wait = 0, m_pend = 0;
  int n_left, n_stall, n_flush;
  bit n_wait, n_pend;
  bit frozen, take, stall, haz;
  bit e_pcs, e_ems, e_bub, e_fl;
  int e_sel, e_sc, e_fc;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .id_inst      (id_inst),
    .ex_rd        (ex_rd),
    .ex_wb        (ex_wb),
    .ex_load      (ex_load),
    .mem_rd       (mem_rd),
    .mem_load     (mem_load),
    .redirect     (redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_stall (ex_mem_stall),
    .pc_sel       (pc_sel),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, rd, op};
  endfunction

  // 2'b11 = reads rs1 and rs2, 2'b01 = rs1 only, 0 = none
  function automatic bit [1:0] sources(input logic [6:0] op);
    case (op)
      7'h33, 7'h3B, 7'h63, 7'h23: return 2'b11;
      7'h13, 7'h1B, 7'h03, 7'h67: return 2'b01;
      default:                    return 2'b00;
    endcase
  endfunction

  function automatic bit model_hazard();
    bit [1:0]   src;
    logic [4:0] a, b;
    bit         lu, jd;
    src = sources(id_inst[6:0]);
    a   = id_inst[19:15];
    b   = id_inst[24:20];
    lu  = ex_load && ex_rd != 0 && ((src[0] && ex_rd == a) || (src[1] && ex_rd == b));
    jd  = id_inst[6:0] == 7'h67 && a != 0 &&
          ((ex_wb && ex_rd == a) || (mem_load && mem_rd == a));
    return lu || jd;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: evaluate the rules for the current inputs and check
  // every DUT output mid-cycle.
  always @(negedge CLK) begin
    if (reset) begin
      {e_pcs, e_ems, e_bub, e_fl} = '0;
      e_sel = 0; e_sc = 0; e_fc = 0;
      n_left = 0; n_wait = 0; n_pend = 0; n_stall = 0; n_flush = 0;
    end else begin
      haz    = model_hazard();
      frozen = m_wait ? !mem_ready : (m_left == 0 && mem_req && !mem_ready);
      take   = !frozen && (redirect || (m_wait && m_pend));
      stall  = !frozen && !take && m_left == 0 && haz;
      e_pcs  = frozen || stall;
      e_ems  = frozen;
      e_bub  = take || stall;
      e_fl   = take || m_left > 0;
      e_sel  = take ? 1 : 0;
      e_sc   = m_stall;
      e_fc   = m_flush;
      n_wait = frozen;
      n_pend = frozen && (m_pend || redirect);
      n_left = take ? FC - 1 : (m_left > 0 ? m_left - 1 : 0);
      n_stall = (m_stall + int'(e_pcs) > SAT) ? SAT : m_stall + int'(e_pcs);
      n_flush = (m_flush + int'(take)  > SAT) ? SAT : m_flush + int'(take);
    end
    checkOutput("m_pc_stall",     int'(pc_stall),     int'(e_pcs));
    checkOutput("m_if_id_stall",  int'(if_id_stall),  int'(e_pcs));
    checkOutput("m_ex_mem_stall", int'(ex_mem_stall), int'(e_ems));
    checkOutput("m_id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
    checkOutput("m_if_id_flush",  int'(if_id_flush),  int'(e_fl));
    checkOutput("m_pc_sel",       int'(pc_sel),       e_sel);
    checkOutput("m_stall_cnt",    int'(stall_cnt),    e_sc);
    checkOutput("m_flush_cnt",    int'(flush_cnt),    e_fc);
  end

  always @(posedge CLK) begin
    if (reset) begin
      m_left <= 0; m_wait <= 0; m_pend <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_left <= n_left; m_wait <= n_wait; m_pend <= n_pend;
      m_stall <= n_stall; m_flush <= n_flush;
    end
  end

  // Drive one cycle of inputs just after the clock edge, then return shortly
  // after the mid-cycle compare so spot checks see settled outputs.
  task automatic applyStimulus(input logic [31:0] inst, input logic [4:0] erd,
                               input logic ewb, input logic eld,
                               input logic [4:0] mrd, input logic mld,
                               input logic rdr, input logic mrq, input logic mrdy);
    @(posedge CLK); #1;
    id_inst = inst; ex_rd = erd; ex_wb = ewb; ex_load = eld;
    mem_rd = mrd; mem_load = mld; redirect = rdr; mem_req = mrq; mem_ready = mrdy;
    @(negedge CLK); #1;
  endtask

  task automatic idle();
    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] add156, add165, addi, sd34, lui5, add00, jalr7, jalr8;
    add156 = enc(7'h33, 1, 5, 6);
    add165 = enc(7'h33, 1, 6, 5);
    addi   = enc(7'h13, 2, 9, 10);
    sd34   = enc(7'h23, 0, 3, 4);
    lui5   = enc(7'h37, 5, 5, 5);
    add00  = enc(7'h33, 1, 0, 0);
    jalr7  = enc(7'h67, 0, 7, 0);
    jalr8  = enc(7'h67, 0, 8, 0);

    reset = 1'b1;
    id_inst = NOP; ex_rd = 0; ex_wb = 0; ex_load = 0; mem_rd = 0; mem_load = 0;
    redirect = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_pc_sel", int'(pc_sel), 0);
    checkOutput("reset_stall_cnt", int'(stall_cnt), 0);
    checkOutput("reset_flush_cnt", int'(flush_cnt), 0);
    reset = 1'b0;
    idle();

    // Load-use through rs1, release, then through rs2
    applyStimulus(add156, 5, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("lu_pc_stall", int'(pc_stall), 1);
    checkOutput("lu_bubble", int'(id_ex_bubble), 1);
    checkOutput("lu_ex_mem_stall", int'(ex_mem_stall), 0);
    applyStimulus(add156, 0, 0, 0, 5, 1, 0, 0, 0);
    checkOutput("lu_release", int'(pc_stall), 0);
    checkOutput("lu_stall_cnt", int'(stall_cnt), 1);
    applyStimulus(add165, 5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(addi, 10, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("itype_no_rs2", int'(pc_stall), 0);
    applyStimulus(sd34, 4, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("store_rs2", int'(pc_stall), 1);
    applyStimulus(lui5, 5, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("lui_no_stall", int'(pc_stall), 0);
    applyStimulus(add00, 0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("x0_no_stall", int'(pc_stall), 0);

    // JALR after a load: two stall cycles, then release
    applyStimulus(jalr7, 7, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(jalr7, 0, 0, 0, 7, 1, 0, 0, 0);
    checkOutput("jalr_load_2nd", int'(pc_stall), 1);
    applyStimulus(jalr7, 0, 0, 0, 7, 0, 0, 0, 0);
    checkOutput("jalr_load_rel", int'(pc_stall), 0);
    // JALR after an ALU op: one stall cycle
    applyStimulus(jalr8, 8, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("jalr_alu", int'(pc_stall), 1);
    applyStimulus(jalr8, 0, 0, 0, 8, 0, 0, 0, 0);
    checkOutput("jalr_alu_rel", int'(pc_stall), 0);
    checkOutput("jalr_stall_cnt", int'(stall_cnt), 6);

    // Redirect with FLUSH_CYCLES=3; hazards ignored while flushing
    applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rd_pc_sel", int'(pc_sel), 1);
    checkOutput("rd_flush", int'(if_id_flush), 1);
    applyStimulus(add156, 5, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("fl1_flush", int'(if_id_flush), 1);
    checkOutput("fl1_pc_sel", int'(pc_sel), 0);
    checkOutput("fl1_no_stall", int'(pc_stall), 0);
    applyStimulus(add156, 5, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("fl2_flush", int'(if_id_flush), 1);
    idle();
    checkOutput("fl_done", int'(if_id_flush), 0);
    checkOutput("fl_cnt", int'(flush_cnt), 1);

    // Memory wait with redirect held: freeze 4 cycles, apply once on ready
    for (int i = 0; i < 4; i++) begin
      applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("mw_ex_mem_stall", int'(ex_mem_stall), 1);
      checkOutput("mw_pc_sel", int'(pc_sel), 0);
    end
    applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("mw_ready_pc_sel", int'(pc_sel), 1);
    checkOutput("mw_ready_nostall", int'(pc_stall), 0);
    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mw_once", int'(pc_sel), 0);
    idle();
    idle();
    checkOutput("mw_flush_cnt", int'(flush_cnt), 2);
    checkOutput("mw_stall_cnt", int'(stall_cnt), 10);

    // Pending redirect only, then a restart during the flush
    applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("pend_pc_sel", int'(pc_sel), 1);
    applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("restart_pc_sel", int'(pc_sel), 1);
    idle();
    idle();
    idle();
    checkOutput("restart_flush_cnt", int'(flush_cnt), 4);

    // Hazard visible on the memory-ready cycle
    applyStimulus(add156, 5, 1, 1, 0, 0, 0, 1, 0);
    applyStimulus(add156, 5, 1, 1, 0, 0, 0, 1, 1);
    checkOutput("rdy_haz_stall", int'(pc_stall), 1);
    checkOutput("rdy_haz_ems", int'(ex_mem_stall), 0);
    idle();
    checkOutput("rdy_stall_cnt", int'(stall_cnt), 14);

    // Reset in the middle of a flush
    applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    checkOutput("pre_rst_flush", int'(if_id_flush), 1);
    @(posedge CLK); #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_flush_now", int'(if_id_flush), 0);
    checkOutput("rst_stall_cnt", int'(stall_cnt), 0);
    checkOutput("rst_flush_cnt", int'(flush_cnt), 0);
    @(posedge CLK); #1;
    reset = 1'b0;
    idle();
    checkOutput("post_rst_flush", int'(if_id_flush), 0);

    // Counter saturation
    for (int i = 0; i < SAT + 2; i++) applyStimulus(add156, 5, 1, 1, 0, 0, 0, 0, 0);
    idle();
    checkOutput("stall_sat", int'(stall_cnt), SAT);
    for (int i = 0; i < SAT + 2; i++) applyStimulus(NOP, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    checkOutput("flush_sat", int'(flush_cnt), SAT);

    @(posedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
